seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle radix-2 integer divider: one quotient bit per clock, instead of a single-cycle combinational divide.
- Supports per-operation signed or unsigned mode.
- Detects divide-by-zero and signed overflow, with defined results for both.
- Uses valid/ready handshakes on input and output so it can sit between pipeline stages in the core's execute path with back-pressure.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 2..64.
- SIGNED_EN, 1: 1 = honour in_signed; 0 = signed logic removed and in_signed ignored (always unsigned).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- in_signed  input  1  1 = two's-complement operation.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  flag for the current result: divisor was 0.
- overflow  output  1  flag for the current result: signed MIN / -1.
- busy  output  1  high in CALC or FIX.

Behaviour:
- Reset:
  - rst high forces state IDLE.
  - quotient, remainder, div_by_zero, overflow, out_valid = 0.
  - Internal registers are cleared.
  - Takes effect immediately, including mid-CALC; the in-flight operation is discarded with no output.
- States and transitions:
  - IDLE -> CALC on accept, normal operands.
  - IDLE -> DONE on accept, special case.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> DONE.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> CALC/DONE on out_ready with simultaneous accept.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready at a rising edge.
- On accept, latch:
  - signed-op = in_signed && SIGNED_EN.
  - Operand magnitudes: absolute value if signed-op and MSB set.
  - Sign of quotient = dividend MSB XOR divisor MSB.
  - Sign of remainder = dividend MSB.
  - Iteration counter = WIDTH.
- CALC, one restoring step per cycle:
  - Partial remainder (WIDTH+1 bits) = (rem<<1) | next dividend bit.
  - If partial >= |divisor|: subtract and shift in quotient bit 1; else shift in 0.
  - Counter decrements; leave CALC when it reaches 0.
- FIX (one cycle):
  - Two's-complement negate quotient/remainder per the latched signs, signed-op only.
  - Load the output registers and set out_valid.
- Latency, normal case: accept at edge 0; out_valid high after edge WIDTH+1. One operation in flight at a time.
- Special cases (out_valid high after edge 1, CALC skipped):
  - Divisor == 0: quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1. Applies in both modes.
  - Signed-op, dividend == MIN (1 followed by zeros), divisor == all ones: quotient = dividend, remainder = 0, overflow = 1.
  - Divisor == 0 takes priority, so overflow = 0 in that case.
- Flags:
  - Flags are set only with the result they describe.
  - On every accept they are overwritten by the next result's values.
- Output hold:
  - In DONE, quotient/remainder/flags/out_valid are stable while out_ready is low.
  - out_valid drops after the edge where out_ready is high, unless a simultaneous accept takes the DONE->DONE path.
  - DONE->DONE (special-case accept with out_ready high): out_valid stays high and the outputs update to the new result.
- Unsigned mode: operand MSBs have no sign meaning; 0xFF/0x01 (WIDTH=8) gives quotient 0xFF, remainder 0.
- Invariant (not special case): dividend = quotient*divisor + remainder, with |remainder| < |divisor|. In signed mode, remainder is 0 or has the dividend's sign.
- busy is combinational from state; in_ready never depends combinationally on in_valid.

Test Plan:
- WIDTH=8, unsigned 100/7 -> after 10 edges: out_valid=1, quotient=14, remainder=2, flags 0; busy high for edges 1..9.
- Signed -7/2 (0xF9/0x02) -> quotient 0xFD (-3), remainder 0xFF (-1). Signed 7/-2 -> quotient 0xFD, remainder 0x01.
- Unsigned 0x35/0 -> after 1 edge: quotient 0xFF, remainder 0x35, div_by_zero=1, overflow=0.
- Signed 0x80/0xFF -> quotient 0x80, remainder 0x00, overflow=1. Same operands unsigned -> quotient 0x00, remainder 0x80, overflow=0.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0 and new in_valid ignored.
  - Then out_ready=1 with in_valid=1 on the same edge: new operation accepted, no result lost.
- Reset mid-CALC: assert rst at edge 4 of 100/7 -> all outputs 0 immediately, state IDLE.
  - After release, 50/5 gives quotient 10, remainder 0, with no stale data.

Source files
------------

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result valid-ready bundle for seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
    logic             busy;
    modport master (
        output in_valid, in_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );
    modport slave (
        input  in_valid, in_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock, signed/unsigned,
// valid/ready on both sides with divide-by-zero and MIN/-1 overflow shortcuts.
module seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, dsr, rem, rem_sub, a_abs, b_abs, min_val;
    logic [WIDTH:0]   part;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg, sop_in, zero_div, ovf, special, accept, fit;
    assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
    assign sop_in   = SIGNED_EN && bus.in_signed;
    assign zero_div = bus.divisor == '0;
    assign ovf      = sop_in && bus.dividend == min_val && bus.divisor == '1;
    assign special  = zero_div || ovf;
    assign accept   = bus.in_valid && bus.in_ready;
    assign a_abs    = (sop_in && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign b_abs    = (sop_in && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
    // acc shifts dividend bits out the top while quotient bits enter at the bottom
    assign part     = {rem, acc[WIDTH-1]};
    assign fit      = part >= {1'b0, dsr};
    assign rem_sub  = part[WIDTH-1:0] - dsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC: state_nx = cnt == CW'(1) ? FIX : CALC;
            FIX:  state_nx = DONE;
            DONE: state_nx = accept ? (special ? DONE : CALC) : bus.out_ready ? IDLE : DONE;
        endcase
    end
    always_comb begin
        bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
        bus.busy     = state == CALC || state == FIX;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc             <= '0;
            dsr             <= '0;
            rem             <= '0;
            cnt             <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.out_valid   <= 1'b0;
        end else if (accept) begin
            acc             <= a_abs;
            dsr             <= b_abs;
            rem             <= '0;
            cnt             <= CW'(WIDTH);
            q_neg           <= sop_in && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg           <= sop_in && bus.dividend[WIDTH-1];
            bus.div_by_zero <= zero_div;
            bus.overflow    <= ovf && !zero_div;
            bus.out_valid   <= special;
            if (special) begin
                bus.quotient  <= zero_div ? '1 : bus.dividend;
                bus.remainder <= zero_div ? bus.dividend : '0;
            end
        end else if (state == CALC) begin
            rem <= fit ? rem_sub : part[WIDTH-1:0];
            acc <= {acc[WIDTH-2:0], fit};
            cnt <= cnt - CW'(1);
        end else if (state == FIX) begin
            bus.quotient  <= q_neg ? -acc : acc;
            bus.remainder <= r_neg ? -rem : rem;
            bus.out_valid <= 1'b1;
        end else if (state == DONE && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random scoreboard checks of seq_divider at WIDTH=8.
module tb_seq_divider;
    localparam int W = 8;
    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors = 0;
    res_t sb[$];
    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m = '0;
        if (b == 0) begin
            m.q = '1;
            m.r = a;
            m.dz = 1'b1;
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            m.q = a;
            m.ov = 1'b1;
        end else if (s) begin
            m.q = W'($signed(a) / $signed(b));
            m.r = W'($signed(a) % $signed(b));
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
    endtask
    // accept the driven operands on the next edge, then wait for and score the result
    task automatic collect;
        res_t e;
        int   lat;
        int   busy_n = 0;
        bit   sp;
        check("in_ready_at_accept", bus.in_ready, 1);
        sb.push_back(model(bus.in_signed, bus.dividend, bus.divisor));
        sp = sb[$].dz || sb[$].ov;
        tick;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            busy_n += int'(bus.busy);
            tick;
            lat++;
        end
        check("latency", lat, sp ? 1 : W + 2);
        check("busy_cycles", busy_n, sp ? 0 : W + 1);
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", bus.div_by_zero, e.dz);
        check("overflow", bus.overflow, e.ov);
    endtask
    task automatic consume;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask
    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_signed = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        tick;
        drive(0, 8'd100, 8'd7);  collect; check("q_100_7", bus.quotient, 14); check("r_100_7", bus.remainder, 2); consume;
        drive(1, 8'hF9, 8'h02);  collect; check("q_m7_2", bus.quotient, 8'hFD); check("r_m7_2", bus.remainder, 8'hFF); consume;
        drive(1, 8'h07, 8'hFE);  collect; check("q_7_m2", bus.quotient, 8'hFD); check("r_7_m2", bus.remainder, 8'h01); consume;
        drive(0, 8'h35, 8'h00);  collect; check("dz_q", bus.quotient, 8'hFF); check("dz_flag", bus.div_by_zero, 1); consume;
        drive(1, 8'h80, 8'hFF);  collect; check("ovf_q", bus.quotient, 8'h80); check("ovf_flag", bus.overflow, 1); consume;
        drive(0, 8'h80, 8'hFF);  collect; check("u80_r", bus.remainder, 8'h80); check("u80_ovf", bus.overflow, 0); consume;
        drive(0, 8'hFF, 8'h01);  collect; check("uff_q", bus.quotient, 8'hFF); consume;
        drive(1, 8'h80, 8'h00);  collect; check("dz_over_ovf", bus.overflow, 0); consume;
        // back-pressure: result held, new operands refused until out_ready
        drive(0, 8'd100, 8'd7);
        collect;
        drive(0, 8'd50, 8'd5);
        repeat (5) begin
            tick;
            check("hold_valid", bus.out_valid, 1);
            check("hold_q", bus.quotient, 14);
            check("hold_r", bus.remainder, 2);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        collect;
        check("bp_q", bus.quotient, 10);
        consume;
        // DONE->DONE: special-case accept while consuming keeps out_valid high
        drive(1, 8'hF9, 8'h02);
        collect;
        drive(0, 8'h35, 8'h00);
        bus.out_ready = 1'b1;
        #1;
        collect;
        check("dd_r", bus.remainder, 8'h35);
        consume;
        // reset mid-calculation
        drive(0, 8'd100, 8'd7);
        tick;
        bus.in_valid = 1'b0;
        repeat (3) tick;
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_q", bus.quotient, 0);
        check("arst_r", bus.remainder, 0);
        check("arst_dz", bus.div_by_zero, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        tick;
        rst = 1'b0;
        repeat (3) tick;
        check("no_stale_valid", bus.out_valid, 0);
        drive(0, 8'd50, 8'd5);
        collect;
        check("post_rst_q", bus.quotient, 10);
        check("post_rst_r", bus.remainder, 0);
        consume;
        for (int i = 0; i < 16; i++) begin
            drive(i[0], W'($urandom_range(0, 255)), (i % 4 == 3) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255)));
            collect;
            consume;
        end
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
